// File: rtl/wash_pkg.sv
// Shared definitions for the wash cycle controller: state encoding and
// default timing constants.
package wash_pkg;

   // State codes are visible on state_o, so the numeric values are fixed.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FILL      = 3'd1,
      S_DETERGENT = 3'd2,
      S_AGITATE   = 3'd3,
      S_DRAIN     = 3'd4,
      S_SPIN      = 3'd5
   } wash_state_e;

   localparam int unsigned DEF_WASH_TICKS  = 16;
   localparam int unsigned DEF_RINSE_TICKS = 8;
   localparam int unsigned DEF_SPIN_TICKS  = 12;
   localparam int unsigned DEF_RINSES      = 2;
   localparam int unsigned DEF_TIMER_W     = 8;

endpackage

// File: rtl/wash_timer.sv
// Loadable down-counter used for agitation and spin durations.
// Load wins over enable; the count saturates at zero and expired is
// high whenever the count is zero.
module wash_timer
   import wash_pkg::*;
#(
   parameter int unsigned TIMER_W = DEF_TIMER_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               enable,
   output logic               expired,
   output logic [TIMER_W-1:0] count
);

   // Count register: load a duration, then step down while enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (enable && (count != '0)) begin
         count <= count - TIMER_W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Wash program sequencer: fill, detergent (wash pass only), agitate,
// drain, repeated for each rinse pass, then a final spin. Pause holds the
// current step and shuts off actuators; abort drains and returns to idle
// without a done pulse.
module wash_cycle_ctrl
   import wash_pkg::*;
#(
   parameter int unsigned WASH_TICKS  = DEF_WASH_TICKS,
   parameter int unsigned RINSE_TICKS = DEF_RINSE_TICKS,
   parameter int unsigned SPIN_TICKS  = DEF_SPIN_TICKS,
   parameter int unsigned RINSES      = DEF_RINSES,
   parameter int unsigned TIMER_W     = DEF_TIMER_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       door_closed,
   input  logic       water_full,
   input  logic       water_empty,
   input  logic       detergent_added,
   input  logic       pause,
   input  logic       abort,
   output logic       door_lock,
   output logic       fill_valve,
   output logic       drain_valve,
   output logic       motor_on,
   output logic       detergent_req,
   output logic       done,
   output logic [2:0] state_o,
   output logic [2:0] pass_o
);

   // The timer counts duration-1 down to 0, so the step lasts exactly
   // duration unpaused cycles including the cycle that sees expiry.
   localparam logic [TIMER_W-1:0] WASH_LD  = TIMER_W'(WASH_TICKS - 1);
   localparam logic [TIMER_W-1:0] RINSE_LD = TIMER_W'(RINSE_TICKS - 1);
   localparam logic [TIMER_W-1:0] SPIN_LD  = TIMER_W'(SPIN_TICKS - 1);
   localparam logic [2:0]         LAST_PASS = 3'(RINSES);

   wash_state_e        state_q, state_d;
   logic [2:0]         pass_q, pass_d;
   logic               skip_q, skip_d;
   logic               done_q, done_d;
   logic               timer_load;
   logic [TIMER_W-1:0] timer_val;
   logic               timer_en;
   logic               timer_exp;
   logic [TIMER_W-1:0] timer_count;
   logic               abortable;

   assign abortable = (state_q == S_FILL) || (state_q == S_DETERGENT) ||
                      (state_q == S_AGITATE) || (state_q == S_SPIN);

   // The timer only runs in the timed steps and freezes while paused.
   assign timer_en = ((state_q == S_AGITATE) || (state_q == S_SPIN)) && !pause;

   wash_timer #(
      .TIMER_W (TIMER_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_val),
      .enable   (timer_en),
      .expired  (timer_exp),
      .count    (timer_count)
   );

   // State, pass counter, skip-spin flag and done pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pass_q  <= 3'd0;
         skip_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
         skip_q  <= skip_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic, timer load requests and Moore outputs.
   always_comb begin
      state_d       = state_q;
      pass_d        = pass_q;
      skip_d        = skip_q;
      done_d        = 1'b0;
      timer_load    = 1'b0;
      timer_val     = '0;
      door_lock     = 1'b0;
      fill_valve    = 1'b0;
      drain_valve   = 1'b0;
      motor_on      = 1'b0;
      detergent_req = 1'b0;

      if (abort && abortable) begin
         // Abort beats pause, timeouts and sensors: drain, then go idle.
         state_d = S_DRAIN;
         pass_d  = LAST_PASS;
         skip_d  = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && door_closed) begin
                  state_d = S_FILL;
                  pass_d  = 3'd0;
                  skip_d  = 1'b0;
               end
            end
            S_FILL: begin
               if (!pause && water_full) begin
                  if (pass_q == 3'd0) begin
                     state_d = S_DETERGENT;
                  end else begin
                     state_d    = S_AGITATE;
                     timer_load = 1'b1;
                     timer_val  = RINSE_LD;
                  end
               end
            end
            S_DETERGENT: begin
               if (!pause && detergent_added) begin
                  state_d    = S_AGITATE;
                  timer_load = 1'b1;
                  timer_val  = (pass_q == 3'd0) ? WASH_LD : RINSE_LD;
               end
            end
            S_AGITATE: begin
               if (!pause && timer_exp) begin
                  state_d = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (water_empty) begin
                  if (skip_q) begin
                     state_d = S_IDLE;
                     skip_d  = 1'b0;
                  end else if (pass_q != LAST_PASS) begin
                     state_d = S_FILL;
                     pass_d  = pass_q + 3'd1;
                  end else begin
                     state_d    = S_SPIN;
                     timer_load = 1'b1;
                     timer_val  = SPIN_LD;
                  end
               end
            end
            S_SPIN: begin
               if (!pause && timer_exp) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      door_lock     = (state_q != S_IDLE);
      fill_valve    = (state_q == S_FILL) && !pause;
      detergent_req = (state_q == S_DETERGENT) && !pause;
      motor_on      = ((state_q == S_AGITATE) || (state_q == S_SPIN)) && !pause;
      drain_valve   = (state_q == S_DRAIN) || ((state_q == S_SPIN) && !pause);
   end

   assign state_o = state_q;
   assign pass_o  = pass_q;
   assign done    = done_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl: a vector table plus hand-built
// sequences for abort-at-expiry, reset during spin and the no-rinse build.
module tb_wash_cycle_ctrl;

   localparam logic [2:0] ST_I  = 3'd0;
   localparam logic [2:0] ST_F  = 3'd1;
   localparam logic [2:0] ST_D  = 3'd2;
   localparam logic [2:0] ST_A  = 3'd3;
   localparam logic [2:0] ST_DR = 3'd4;
   localparam logic [2:0] ST_S  = 3'd5;
   localparam int W = 12;

   logic clk;
   logic reset;
   logic start_a, start_b;
   logic door_closed, water_full, water_empty, detergent_added;
   logic pause, abort;

   logic       door_lock_a, fill_a, drain_a, motor_a, det_a, done_a;
   logic [2:0] state_a, pass_a;
   logic       door_lock_b, fill_b, drain_b, motor_b, det_b, done_b;
   logic [2:0] state_b, pass_b;

   typedef struct {
      logic       start;
      logic       door;
      logic       pause;
      logic       abort;
      logic [2:0] st;
      logic [2:0] ps;
      logic       dn;
   } vec_t;

   vec_t         tbl[$];
   logic [W-1:0] exp_q[$];
   int           n_tests;
   int           n_fail;

   wash_cycle_ctrl #(
      .WASH_TICKS (4), .RINSE_TICKS (2), .SPIN_TICKS (3), .RINSES (1), .TIMER_W (8)
   ) u_dut_a (
      .clk (clk), .reset (reset), .start (start_a), .door_closed (door_closed),
      .water_full (water_full), .water_empty (water_empty),
      .detergent_added (detergent_added), .pause (pause), .abort (abort),
      .door_lock (door_lock_a), .fill_valve (fill_a), .drain_valve (drain_a),
      .motor_on (motor_a), .detergent_req (det_a), .done (done_a),
      .state_o (state_a), .pass_o (pass_a)
   );

   wash_cycle_ctrl #(
      .WASH_TICKS (4), .RINSE_TICKS (2), .SPIN_TICKS (3), .RINSES (0), .TIMER_W (8)
   ) u_dut_b (
      .clk (clk), .reset (reset), .start (start_b), .door_closed (door_closed),
      .water_full (water_full), .water_empty (water_empty),
      .detergent_added (detergent_added), .pause (pause), .abort (abort),
      .door_lock (door_lock_b), .fill_valve (fill_b), .drain_valve (drain_b),
      .motor_on (motor_b), .detergent_req (det_b), .done (done_b),
      .state_o (state_b), .pass_o (pass_b)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected actuator pattern {door_lock, fill, drain, motor, det_req, done}
   function automatic logic [5:0] exp_outs(input logic [2:0] st, input logic p,
                                            input logic dn);
      logic dl, fv, dv, mo, dr;
      dl = (st != ST_I);
      fv = (st == ST_F) && !p;
      dr = (st == ST_D) && !p;
      mo = ((st == ST_A) || (st == ST_S)) && !p;
      dv = (st == ST_DR) || ((st == ST_S) && !p);
      return {dl, fv, dv, mo, dr, dn};
   endfunction

   // Pop the oldest expectation and compare it with the selected DUT.
   task automatic check(input int sel, input string name);
      logic [W-1:0] got, exp;
      got = (sel == 0) ?
            {state_a, pass_a, door_lock_a, fill_a, drain_a, motor_a, det_a, done_a} :
            {state_b, pass_b, door_lock_b, fill_b, drain_b, motor_b, det_b, done_b};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got st=%0d pass=%0d outs=%b, expected st=%0d pass=%0d outs=%b",
                  name, got[11:9], got[8:6], got[5:0], exp[11:9], exp[8:6], exp[5:0]);
      end
   endtask

   // Drive one cycle of inputs and check the state/outputs seen in that cycle.
   task automatic step(input int sel, input logic s, input logic d, input logic p,
                       input logic a, input logic [2:0] es, input logic [2:0] ep,
                       input logic ed, input string name);
      @(negedge clk);
      start_a     = (sel == 0) ? s : 1'b0;
      start_b     = (sel == 1) ? s : 1'b0;
      door_closed = d;
      pause       = p;
      abort       = a;
      exp_q.push_back({es, ep, exp_outs(es, p, ed)});
      #1;
      check(sel, name);
   endtask

   task automatic add(input logic s, input logic d, input logic p, input logic a,
                      input logic [2:0] st, input logic [2:0] ps, input logic dn);
      vec_t v;
      v.start = s; v.door = d; v.pause = p; v.abort = a;
      v.st = st; v.ps = ps; v.dn = dn;
      tbl.push_back(v);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // Door open: start is refused
      add(1, 0, 0, 0, ST_I, 0, 0);
      add(0, 0, 0, 0, ST_I, 0, 0);
      // Full program, door sensor dropping mid-run is ignored
      add(1, 1, 0, 0, ST_I, 0, 0);
      add(0, 1, 0, 0, ST_F, 0, 0);
      add(0, 1, 0, 0, ST_D, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, ST_A, 0, 0);
      add(0, 0, 0, 0, ST_DR, 0, 0);
      add(0, 0, 0, 0, ST_F, 1, 0);
      for (int i = 0; i < 2; i++) add(0, 0, 0, 0, ST_A, 1, 0);
      add(0, 0, 0, 0, ST_DR, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, ST_S, 1, 0);
      add(0, 0, 0, 0, ST_I, 1, 1);
      add(0, 0, 0, 0, ST_I, 1, 0);
      // Pause in FILL, 5-cycle pause in 2nd AGITATE cycle, pause in DRAIN,
      // then abort during the rinse fill
      add(1, 1, 0, 0, ST_I, 1, 0);
      add(0, 1, 1, 0, ST_F, 0, 0);
      add(0, 1, 1, 0, ST_F, 0, 0);
      add(0, 1, 0, 0, ST_F, 0, 0);
      add(0, 1, 0, 0, ST_D, 0, 0);
      add(0, 1, 0, 0, ST_A, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 1, 1, 0, ST_A, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, ST_A, 0, 0);
      add(0, 1, 1, 0, ST_DR, 0, 0);
      add(0, 1, 0, 1, ST_F, 1, 0);
      add(0, 1, 0, 0, ST_DR, 1, 0);
      add(0, 1, 0, 0, ST_I, 1, 0);

      // Reset block
      reset = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      door_closed = 1'b0; pause = 1'b0; abort = 1'b0;
      water_full = 1'b1; water_empty = 1'b1; detergent_added = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      exp_q.push_back({ST_I, 3'd0, 6'd0});
      check(0, "reset_a");
      exp_q.push_back({ST_I, 3'd0, 6'd0});
      check(1, "reset_b");
      reset = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < tbl.size(); i++) begin
         step(0, tbl[i].start, tbl[i].door, tbl[i].pause, tbl[i].abort,
              tbl[i].st, tbl[i].ps, tbl[i].dn, $sformatf("tbl[%0d]", i));
      end

      // Abort on the same cycle the agitation timer expires
      step(0, 1, 1, 0, 0, ST_I, 1, 0, "abx_start");
      step(0, 0, 1, 0, 0, ST_F, 0, 0, "abx_fill");
      step(0, 0, 1, 0, 0, ST_D, 0, 0, "abx_det");
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, ST_A, 0, 0, "abx_agi");
      step(0, 0, 1, 0, 1, ST_A, 0, 0, "abx_agi_expire");
      step(0, 0, 1, 0, 0, ST_DR, 1, 0, "abx_drain");
      step(0, 0, 1, 0, 0, ST_I, 1, 0, "abx_idle_nodone");
      step(0, 0, 1, 0, 0, ST_I, 1, 0, "abx_idle_after");

      // Reset pulsed during SPIN (with a paused SPIN cycle first)
      step(0, 1, 1, 0, 0, ST_I, 1, 0, "rs_start");
      step(0, 0, 1, 0, 0, ST_F, 0, 0, "rs_fill0");
      step(0, 0, 1, 0, 0, ST_D, 0, 0, "rs_det");
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, ST_A, 0, 0, "rs_agi0");
      step(0, 0, 1, 0, 0, ST_DR, 0, 0, "rs_drain0");
      step(0, 0, 1, 0, 0, ST_F, 1, 0, "rs_fill1");
      for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0, ST_A, 1, 0, "rs_agi1");
      step(0, 0, 1, 0, 0, ST_DR, 1, 0, "rs_drain1");
      step(0, 0, 1, 1, 0, ST_S, 1, 0, "rs_spin_paused");
      step(0, 0, 1, 0, 0, ST_S, 1, 0, "rs_spin");
      @(negedge clk);
      reset = 1'b1;
      start_a = 1'b1;
      exp_q.push_back({ST_I, 3'd0, 6'd0});
      #1;
      check(0, "rs_async");
      @(negedge clk);
      exp_q.push_back({ST_I, 3'd0, 6'd0});
      #1;
      check(0, "rs_start_ignored");
      start_a = 1'b0;
      reset = 1'b0;
      step(0, 0, 1, 0, 0, ST_I, 0, 0, "rs_no_done");

      // No-rinse build: DRAIN after the wash goes straight to SPIN
      step(1, 1, 1, 0, 0, ST_I, 0, 0, "nr_start");
      step(1, 0, 1, 0, 0, ST_F, 0, 0, "nr_fill");
      step(1, 0, 1, 0, 0, ST_D, 0, 0, "nr_det");
      for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, ST_A, 0, 0, "nr_agi");
      step(1, 0, 1, 0, 0, ST_DR, 0, 0, "nr_drain");
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, ST_S, 0, 0, "nr_spin");
      step(1, 0, 1, 0, 0, ST_I, 0, 1, "nr_done");
      step(1, 0, 1, 0, 0, ST_I, 0, 0, "nr_idle");

      // Report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wash_cycle_ctrl.md
WASH_CYCLE_CTRL -- requirements
Module: wash_cycle_ctrl

Interface
REQ-001 SHALL have parameter WASH_TICKS, default 16, wash agitation duration in clk cycles (>=1).
REQ-002 SHALL have parameter RINSE_TICKS, default 8, rinse agitation duration in clk cycles (>=1).
REQ-003 SHALL have parameter SPIN_TICKS, default 12, spin duration in clk cycles (>=1).
REQ-004 SHALL have parameter RINSES, default 2, number of rinse passes after the wash pass (0..7).
REQ-005 SHALL have parameter TIMER_W, default 8, timer width; every *_TICKS value SHALL fit in TIMER_W bits.
REQ-006 Ports:
clk  input  1  single clock; all state changes on rising edge
reset  input  1  asynchronous, active-high
start  input  1  begin a program from IDLE
door_closed  input  1  door sensor, 1 = closed
water_full  input  1  level sensor, drum full
water_empty  input  1  level sensor, drum empty
detergent_added  input  1  dispenser confirms detergent released
pause  input  1  level-sensitive hold
abort  input  1  one-cycle cancel request
door_lock  output  1  door latch engaged
fill_valve  output  1  inlet valve open
drain_valve  output  1  drain valve/pump on
motor_on  output  1  drum motor on
detergent_req  output  1  request detergent release
done  output  1  one-cycle pulse at program end
state_o  output  3  current state code
pass_o  output  3  current pass: 0 = wash, 1..RINSES = rinse

Function
REQ-007 States: IDLE, FILL, DETERGENT, AGITATE, DRAIN, SPIN.
REQ-008 IDLE -> FILL when start=1 and door_closed=1 in the same cycle; pass_o cleared to 0; otherwise hold.
REQ-009 FILL -> DETERGENT on water_full=1 when pass_o=0; FILL -> AGITATE on water_full=1 when pass_o>0.
REQ-010 DETERGENT -> AGITATE on detergent_added=1.
REQ-011 AGITATE lasts exactly WASH_TICKS (pass 0) or RINSE_TICKS (pass>0) unpaused cycles, then -> DRAIN.
REQ-012 DRAIN on water_empty=1: if pass_o<RINSES, increment pass_o and go to FILL; else go to SPIN.
REQ-013 SPIN lasts exactly SPIN_TICKS unpaused cycles, then -> IDLE with done=1 for that single transition cycle.
REQ-014 Moore outputs decoded from registered state: door_lock=1 in every state except IDLE; fill_valve=1 in FILL; detergent_req=1 in DETERGENT; motor_on=1 in AGITATE and SPIN; drain_valve=1 in DRAIN and SPIN.
REQ-015 pause=1 in AGITATE or SPIN SHALL freeze the timer and force motor_on=0 and drain_valve=0; the state is held; on release counting resumes from the frozen value.
REQ-016 pause=1 in FILL or DETERGENT SHALL force fill_valve=0 and detergent_req=0 and block the transition; pause SHALL have no effect in IDLE or DRAIN.
REQ-017 abort=1 in FILL, DETERGENT, AGITATE or SPIN SHALL go to DRAIN with pass_o forced to RINSES and a skip-spin flag set; DRAIN then exits to IDLE with no done pulse.
REQ-018 abort SHALL take priority over pause and over any same-cycle timeout or sensor event; abort in IDLE or DRAIN SHALL be ignored.
REQ-019 The timer SHALL load (duration-1) on entry to AGITATE or SPIN, decrement each unpaused cycle, and signal expiry at 0; no wrap below 0.
REQ-020 door_closed=0 outside IDLE SHALL be ignored, because the door is latched.
REQ-021 With RINSES=0, DRAIN after pass 0 SHALL go directly to SPIN.

Reset
REQ-022 Reset SHALL asynchronously force state IDLE, pass_o=0, timer=0, skip-spin flag=0, done=0; all Moore outputs SHALL then be 0.
REQ-023 Reset asserted mid-program SHALL abandon the program immediately with no done pulse; start SHALL be ignored while reset=1.

Structure
REQ-024 A shared package wash_pkg SHALL hold the state encoding (IDLE=0, FILL=1, DETERGENT=2, AGITATE=3, DRAIN=4, SPIN=5) and the default tick constants.
REQ-025 The down-counter SHALL be one sub-module, wash_timer (load, enable, expiry output, TIMER_W parameter).

Verification
REQ-026 WASH_TICKS=4, RINSE_TICKS=2, SPIN_TICKS=3, RINSES=1, instant sensors -> state sequence FILL, DET, AGI x4, DRN, FILL, AGI x2, DRN, SPIN x3, IDLE; exactly one done pulse.
REQ-027 start=1 with door_closed=0 -> remains IDLE, all outputs 0.
REQ-028 pause held 5 cycles in the 2nd AGITATE cycle (WASH_TICKS=4) -> motor_on=0 during the pause; AGITATE lasts 9 cycles in total.
REQ-029 abort in AGITATE on the same cycle as timer expiry -> DRAIN; on water_empty -> IDLE, done stays 0, SPIN never entered.
REQ-030 reset pulsed during SPIN -> next cycle state_o=0, pass_o=0, motor_on=0, no done pulse.
REQ-031 RINSES=0 -> DRAIN after wash goes straight to SPIN; pass_o stays 0.
